// File: rtl/uart8_core.sv
// rtl/uart8_core.sv - 8N1 UART: 16x oversampling receiver with framing check, single-byte transmitter
module uart8_core #(
  parameter int CLOCK_RATE = 100000000,
  parameter int BAUD_RATE  = 9600
) (
  input  logic       clk,
  input  logic       rstN,
  input  logic       rxEn,
  input  logic       rxIn,
  output logic       rxBusy,
  output logic       rxDone,
  output logic       rxErr,
  output logic [7:0] rxOut,
  input  logic       txEn,
  input  logic       txStart,
  input  logic [7:0] txIn,
  output logic       txBusy,
  output logic       txDone,
  output logic       txOut
);

  localparam int RXDIV = CLOCK_RATE / (BAUD_RATE * 16);
  localparam int TXDIV = CLOCK_RATE / BAUD_RATE;
  localparam int RXCW  = (RXDIV > 1) ? $clog2(RXDIV) : 1;
  localparam int TXCW  = (TXDIV > 1) ? $clog2(TXDIV) : 1;

  typedef enum logic [2:0] {RX_ARM, RX_IDLE, RX_START, RX_DATA, RX_STOP} rxState_t;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} txState_t;

  // ---------------------------------------------------------------- receiver
  logic            rxSync1, rxSync2, rxPrev;
  rxState_t        rxState, rxNext;
  logic [RXCW-1:0] rxDivCnt;
  logic [3:0]      rxTickCnt;
  logic [2:0]      rxBitCnt;
  logic [7:0]      rxShift;
  logic            rxTick, rxFall;
  logic            rxFrameStart, rxSampleData, rxStopOk, rxStopBad;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      rxSync1 <= 1'b1;
      rxSync2 <= 1'b1;
      rxPrev  <= 1'b1;
    end else begin
      rxSync1 <= rxIn;
      rxSync2 <= rxSync1;
      rxPrev  <= rxSync2;
    end
  end

  assign rxTick = (rxDivCnt == RXCW'(RXDIV - 1));
  assign rxFall = rxPrev & ~rxSync2;
  assign rxBusy = (rxState == RX_START) || (rxState == RX_DATA) || (rxState == RX_STOP);

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) rxState <= RX_ARM;
    else       rxState <= rxNext;
  end

  // ARM/IDLE react every clock so the start edge is caught precisely; the rest steps on ticks
  always_comb begin
    rxNext       = rxState;
    rxFrameStart = 1'b0;
    rxSampleData = 1'b0;
    rxStopOk     = 1'b0;
    rxStopBad    = 1'b0;
    if (!rxEn) begin
      rxNext = RX_ARM;
    end else begin
      case (rxState)
        RX_ARM:   if (rxSync2) rxNext = RX_IDLE;
        RX_IDLE:  if (rxFall) begin
                    rxNext       = RX_START;
                    rxFrameStart = 1'b1;
                  end
        RX_START: if (rxTick && rxTickCnt == 4'd7) rxNext = rxSync2 ? RX_IDLE : RX_DATA;
        RX_DATA:  if (rxTick && rxTickCnt == 4'd15) begin
                    rxSampleData = 1'b1;
                    if (rxBitCnt == 3'd7) rxNext = RX_STOP;
                  end
        RX_STOP:  if (rxTick && rxTickCnt == 4'd15) begin
                    if (rxSync2) begin
                      rxStopOk = 1'b1;
                      rxNext   = RX_IDLE;
                    end else begin
                      rxStopBad = 1'b1;
                      rxNext    = RX_ARM;
                    end
                  end
        default:  rxNext = RX_ARM;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      rxDivCnt  <= '0;
      rxTickCnt <= '0;
      rxBitCnt  <= '0;
      rxShift   <= '0;
      rxOut     <= '0;
      rxDone    <= 1'b0;
      rxErr     <= 1'b0;
    end else begin
      rxDone <= rxStopOk;
      if (!rxEn || rxFrameStart || rxTick) rxDivCnt <= '0;
      else                                 rxDivCnt <= rxDivCnt + 1'b1;
      // tick count wraps 15->0 between data bits; START resets it after the mid-bit sample
      if (!rxEn || rxFrameStart)
        rxTickCnt <= '0;
      else if (rxTick && rxBusy)
        rxTickCnt <= (rxState == RX_START && rxTickCnt == 4'd7) ? 4'd0 : rxTickCnt + 4'd1;
      if (rxFrameStart) begin
        rxBitCnt <= '0;
        rxErr    <= 1'b0;
      end
      if (rxSampleData) begin
        rxShift  <= {rxSync2, rxShift[7:1]};
        rxBitCnt <= rxBitCnt + 3'd1;
      end
      if (rxStopOk)  rxOut <= rxShift;
      if (rxStopBad) rxErr <= 1'b1;
    end
  end

  // ------------------------------------------------------------- transmitter
  txState_t        txState, txNext;
  logic [TXCW-1:0] txDivCnt;
  logic [2:0]      txBitCnt;
  logic [7:0]      txShift, txShiftNext;
  logic            txTick, txFrameStart, txFinish, txOutNext;

  assign txTick = (txDivCnt == TXCW'(TXDIV - 1));
  assign txBusy = (txState != TX_IDLE);

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) txState <= TX_IDLE;
    else       txState <= txNext;
  end

  always_comb begin
    txNext       = txState;
    txFrameStart = 1'b0;
    txFinish     = 1'b0;
    if (!txEn) begin
      txNext = TX_IDLE;
    end else begin
      case (txState)
        TX_IDLE:  if (txStart) begin
                    txNext       = TX_START;
                    txFrameStart = 1'b1;
                  end
        TX_START: if (txTick) txNext = TX_DATA;
        TX_DATA:  if (txTick && txBitCnt == 3'd7) txNext = TX_STOP;
        TX_STOP:  if (txTick) begin
                    txNext   = TX_IDLE;
                    txFinish = 1'b1;
                  end
        default:  txNext = TX_IDLE;
      endcase
    end
  end

  // line value is registered from next-state values so txOut never glitches
  always_comb begin
    txShiftNext = txShift;
    if (txFrameStart)                       txShiftNext = txIn;
    else if (txState == TX_DATA && txTick)  txShiftNext = {1'b1, txShift[7:1]};
    case (txNext)
      TX_START: txOutNext = 1'b0;
      TX_DATA:  txOutNext = txShiftNext[0];
      default:  txOutNext = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      txDivCnt <= '0;
      txBitCnt <= '0;
      txShift  <= '0;
      txOut    <= 1'b1;
      txDone   <= 1'b0;
    end else begin
      txShift <= txShiftNext;
      txOut   <= txOutNext;
      txDone  <= txFinish;
      if (!txEn || txFrameStart || txTick) txDivCnt <= '0;
      else                                 txDivCnt <= txDivCnt + 1'b1;
      if (txFrameStart)                       txBitCnt <= '0;
      else if (txState == TX_DATA && txTick)  txBitCnt <= txBitCnt + 3'd1;
    end
  end

endmodule

// File: tb/tb_uart8_core.sv
// tb/tb_uart8_core.sv - directed self-checking bench for uart8_core at 12 MHz / 9600 baud
`timescale 1ns/1ps
module tb_uart8_core;

  localparam int BIT_CLKS  = 1250;
  localparam int SLOW_CLKS = 1288;

  logic       clk = 1'b0;
  logic       rstN, rxEn, rxLine, loopback, txEn, txStart;
  logic [7:0] txIn;
  logic       rxIn;
  logic       rxBusy, rxDone, rxErr, txBusy, txDone, txOut;
  logic [7:0] rxOut;

  int cmpCnt = 0;
  int errCnt = 0;
  int rxDoneCnt = 0;
  int txDoneCnt = 0;

  assign rxIn = loopback ? txOut : rxLine;

  uart8_core #(.CLOCK_RATE(12000000), .BAUD_RATE(9600)) dut (
    .clk(clk), .rstN(rstN),
    .rxEn(rxEn), .rxIn(rxIn), .rxBusy(rxBusy), .rxDone(rxDone), .rxErr(rxErr), .rxOut(rxOut),
    .txEn(txEn), .txStart(txStart), .txIn(txIn), .txBusy(txBusy), .txDone(txDone), .txOut(txOut)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rxDone) rxDoneCnt++;
    if (txDone) txDoneCnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmpCnt++;
    assert (obs === exp) else begin
      errCnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic waitClks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic sendRx(input logic [7:0] b, input logic stopBit, input int bitClks);
    rxLine = 1'b0;
    waitClks(bitClks);
    for (int i = 0; i < 8; i++) begin
      rxLine = b[i];
      waitClks(bitClks);
    end
    rxLine = stopBit;
    waitClks(bitClks);
    rxLine = 1'b1;
  endtask

  task automatic pulseTx(input logic [7:0] b);
    txIn    = b;
    txStart = 1'b1;
    waitClks(1);
    txStart = 1'b0;
  endtask

  task automatic waitTxIdle(input string tag);
    for (int c = 0; c < 15000 && txBusy; c++) waitClks(1);
    check(tag, 32'(txBusy), 32'(0));
  endtask

  task automatic checkResetValues(input string tag);
    check({tag, " rxBusy"}, 32'(rxBusy), 32'(0));
    check({tag, " rxDone"}, 32'(rxDone), 32'(0));
    check({tag, " rxErr"},  32'(rxErr),  32'(0));
    check({tag, " rxOut"},  32'(rxOut),  32'h00);
    check({tag, " txBusy"}, 32'(txBusy), 32'(0));
    check({tag, " txDone"}, 32'(txDone), 32'(0));
    check({tag, " txOut"},  32'(txOut),  32'(1));
  endtask

  initial begin
    logic [9:0] txExp;
    logic [7:0] lbBytes [3];
    int         prev;
    int         prevTx;

    txExp   = 10'b1101001010;  // A5 framed: 0,1,0,1,0,0,1,0,1,1 from bit 0 upward
    lbBytes = '{8'h00, 8'hFF, 8'h55};

    rstN = 1'b0; rxEn = 1'b1; txEn = 1'b1; rxLine = 1'b1; loopback = 1'b0;
    txStart = 1'b0; txIn = 8'h00;
    waitClks(5);
    checkResetValues("reset");
    rstN = 1'b1;
    waitClks(10);

    // slow receive frame alongside a transmit frame
    fork
      begin
        sendRx(8'h35, 1'b1, SLOW_CLKS);
        check("slow rx rxDone count", 32'(rxDoneCnt), 32'(1));
        check("slow rx rxOut", 32'(rxOut), 32'h35);
        check("slow rx rxErr", 32'(rxErr), 32'(0));
      end
      begin
        prevTx = txDoneCnt;
        pulseTx(8'hA5);
        txIn = 8'h3C;
        waitClks(623);
        check("tx busy mid frame", 32'(txBusy), 32'(1));
        for (int k = 0; k < 10; k++) begin
          if (k > 0) waitClks(BIT_CLKS);
          check($sformatf("tx A5 bit %0d", k), 32'(txOut), 32'(txExp[k]));
        end
        waitClks(1000);
        check("tx A5 txDone count", 32'(txDoneCnt), 32'(prevTx + 1));
        check("tx A5 txBusy after", 32'(txBusy), 32'(0));
      end
    join

    // loopback
    loopback = 1'b1;
    waitClks(5);
    for (int n = 0; n < 3; n++) begin
      prev = rxDoneCnt;
      pulseTx(lbBytes[n]);
      for (int c = 0; c < 14000 && rxDoneCnt == prev; c++) waitClks(1);
      check($sformatf("loop %0d rxDone", n), 32'(rxDoneCnt), 32'(prev + 1));
      check($sformatf("loop %0d rxOut", n), 32'(rxOut), 32'(lbBytes[n]));
      check($sformatf("loop %0d rxErr", n), 32'(rxErr), 32'(0));
      waitTxIdle($sformatf("loop %0d txBusy", n));
    end
    loopback = 1'b0;
    waitClks(20);

    // line low at enable, then a frame with a low stop bit
    rxEn = 1'b0;
    rxLine = 1'b0;
    waitClks(20);
    rxEn = 1'b1;
    waitClks(2000);
    check("arm low line no frame", 32'(rxBusy), 32'(0));
    prev = rxDoneCnt;
    rxLine = 1'b1;
    waitClks(100);
    sendRx(8'h35, 1'b0, BIT_CLKS);
    check("bad stop rxErr", 32'(rxErr), 32'(1));
    check("bad stop no rxDone", 32'(rxDoneCnt), 32'(prev));
    check("bad stop rxOut held", 32'(rxOut), 32'h55);
    check("bad stop rxBusy", 32'(rxBusy), 32'(0));
    waitClks(100);

    // short low glitch on idle line
    prev = rxDoneCnt;
    rxLine = 1'b0;
    waitClks(20);
    check("glitch seen busy", 32'(rxBusy), 32'(1));
    waitClks(214);
    rxLine = 1'b1;
    waitClks(1000);
    check("glitch rxBusy", 32'(rxBusy), 32'(0));
    check("glitch rxErr", 32'(rxErr), 32'(0));
    check("glitch no rxDone", 32'(rxDoneCnt), 32'(prev));
    check("glitch rxOut", 32'(rxOut), 32'h55);

    // reset in the middle of both frames
    pulseTx(8'h0F);
    rxLine = 1'b0;
    waitClks(3000);
    check("pre-reset rxBusy", 32'(rxBusy), 32'(1));
    check("pre-reset txBusy", 32'(txBusy), 32'(1));
    rstN = 1'b0;
    #1;
    checkResetValues("mid reset");
    rxLine = 1'b1;
    waitClks(5);
    rstN = 1'b1;
    waitClks(10);
    check("post reset txOut", 32'(txOut), 32'(1));
    check("post reset txBusy", 32'(txBusy), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCnt, errCnt);
    $finish;
  end

endmodule
